// File: rtl/call_responder.sv
// Nurse-call attendant responder: round-robin room arbitration, ack-driven
// cancel pulse, escalation on overdue calls and bounded wait for light clear.
module call_responder #(
  parameter int N_ROOMS     = 4,
  parameter int ESC_LIMIT   = 16,
  parameter int CLR_TIMEOUT = 4,
  localparam int RW = (N_ROOMS > 1) ? $clog2(N_ROOMS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ROOMS-1:0] call_lights,
  input  logic               ack,
  output logic [N_ROOMS-1:0] cancel_out,
  output logic               busy,
  output logic [RW-1:0]      room_id,
  output logic               escalate,
  output logic [N_ROOMS-1:0] pending
);

  localparam int EW = $clog2(ESC_LIMIT + 1);
  localparam int TW = $clog2(CLR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    CANCEL,
    WAIT_CLR
  } state_t;

  state_t             state, state_n;
  logic [RW-1:0]      room_n;
  logic [RW-1:0]      last_ptr, ptr_n;
  logic [EW-1:0]      esc_cnt, esc_n;
  logic [TW-1:0]      to_cnt, to_n;
  logic               ack_q;
  logic               ack_edge;
  logic [N_ROOMS-1:0] cancel_q;
  logic [RW-1:0]      win;
  logic               win_ok;
  logic [RW-1:0]      cand;

  assign ack_edge = ack & ~ack_q;

  // Search starts one past the last served room and wraps.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_ROOMS; k++) begin
      cand = RW'((int'(last_ptr) + k) % N_ROOMS);
      if (!win_ok && call_lights[cand]) begin
        win_ok = 1'b1;
        win    = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    room_n  = room_id;
    ptr_n   = last_ptr;
    esc_n   = esc_cnt;
    to_n    = to_cnt;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          room_n  = win;
          esc_n   = '0;
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (esc_cnt != EW'(ESC_LIMIT))
          esc_n = esc_cnt + EW'(1);
        // A dropped call beats a coincident ack edge.
        if (!call_lights[room_id]) begin
          state_n = IDLE;
          ptr_n   = room_id;
        end else if (ack_edge) begin
          state_n = CANCEL;
        end
      end
      CANCEL: begin
        to_n    = '0;
        state_n = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!call_lights[room_id] ||
            to_cnt == TW'(CLR_TIMEOUT - 1)) begin
          state_n = IDLE;
          ptr_n   = room_id;
        end else begin
          to_n = to_cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      room_id  <= '0;
      last_ptr <= RW'(N_ROOMS - 1);
      esc_cnt  <= '0;
      to_cnt   <= '0;
      ack_q    <= 1'b1;
      cancel_q <= '0;
      busy     <= 1'b0;
      escalate <= 1'b0;
      pending  <= '0;
    end else begin
      state    <= state_n;
      room_id  <= room_n;
      last_ptr <= ptr_n;
      esc_cnt  <= esc_n;
      to_cnt   <= to_n;
      ack_q    <= ack;
      busy     <= (state_n != IDLE);
      escalate <= (state_n == SERVE) &&
                  (esc_n == EW'(ESC_LIMIT));
      cancel_q <= (state_n == CANCEL) ?
                  (N_ROOMS'(1) << room_n) : '0;
      pending  <= call_lights;
    end
  end

  // Reset kills an in-flight pulse in the same cycle.
  assign cancel_out = reset ? '0 : cancel_q;

endmodule

// File: doc/call_responder.md
CALL_RESPONDER -- requirements
Module: call_responder

Interface
REQ-001 Parameter N_ROOMS, default 4, number of room call units served; the design SHALL support 2..8.
REQ-002 Parameter ESC_LIMIT, default 16, cycles in SERVE before escalation.
REQ-003 Parameter CLR_TIMEOUT, default 4, maximum cycles in WAIT_CLR.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 call_lights  input  N_ROOMS  bit i is room i's light_state, 1 = call active.
REQ-007 ack  input  1  attendant acknowledge button; level input, rising edge detected internally.
REQ-008 cancel_out  output  N_ROOMS  bit i drives room i's cancel input; registered.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE; registered.
REQ-010 room_id  output  clog2(N_ROOMS)  index of the room being served; registered.
REQ-011 escalate  output  1  overdue-call indicator; registered.
REQ-012 pending  output  N_ROOMS  registered copy of call_lights, one cycle delayed.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SERVE, CANCEL and WAIT_CLR.
REQ-014 IDLE: if any call_lights bit is 1, latch the winning index into room_id, go to SERVE next cycle, and clear the escalation counter.
REQ-015 Arbitration SHALL be round-robin: search starts at (last served index + 1) mod N_ROOMS; after reset the search starts at index 0.
REQ-016 SERVE: a rising edge of ack (ack=1 this cycle, 0 the previous cycle) SHALL move the FSM to CANCEL; a held ack SHALL generate only one edge.
REQ-017 SERVE: if call_lights[room_id] falls to 0 before ack, go to IDLE with no cancel pulse; the last-served pointer SHALL still advance.
REQ-018 SERVE: the escalation counter SHALL increment each cycle, saturating at ESC_LIMIT; escalate SHALL be 1 while counter == ESC_LIMIT and the FSM is in SERVE, and 0 in every other state.
REQ-019 CANCEL: cancel_out SHALL be one-hot at room_id for exactly one cycle, then the FSM goes to WAIT_CLR; cancel_out SHALL be all-zero in all other states.
REQ-020 WAIT_CLR: go to IDLE when call_lights[room_id] = 0 or after CLR_TIMEOUT cycles, whichever comes first; the last-served pointer SHALL update to room_id.
REQ-021 A room that re-raises its call, or whose call stays held past the timeout, SHALL be re-arbitrated normally from IDLE with no special priority.
REQ-022 Simultaneous ack rising edge and call drop in SERVE: the call drop SHALL win, so the FSM goes to IDLE and issues no cancel.
REQ-023 Calls from rooms other than room_id SHALL be ignored until the FSM returns to IDLE; they remain visible on pending.
REQ-024 An ack edge detected in any state other than SERVE SHALL be discarded and SHALL NOT be stored.
REQ-025 Latency SHALL be: call_lights rise to busy=1 in 1 cycle; ack edge to cancel_out pulse in 1 cycle.

Reset
REQ-026 When reset is asserted: state = IDLE, busy = 0, room_id = 0, escalate = 0, cancel_out = 0, pending = 0, the escalation counter and timeout counter = 0, the last-served pointer = N_ROOMS-1 (so the first search starts at 0), and the previous-cycle ack register = 1, so an ack already held at reset release produces no edge.
REQ-027 A reset asserted mid-operation, in any state, SHALL take priority over all transitions, and any in-flight cancel pulse SHALL be suppressed in that same cycle.

Verification
REQ-028 call_lights=0100 from IDLE -> next cycle busy=1, room_id=2; ack pulse -> cancel_out=0100 for one cycle; light clears -> IDLE.
REQ-029 call_lights=1111 serviced repeatedly with acks -> rooms served in order 0,1,2,3,0.
REQ-030 call_lights=0001 held with no ack -> escalate=1 on the 16th cycle in SERVE and stays 1; ack -> escalate=0 in CANCEL.
REQ-031 Serving room 1, call_lights[1] drops in the same cycle as the ack edge -> IDLE, cancel_out stays 0000.
REQ-032 After the cancel pulse the room light stays 1 -> WAIT_CLR exits after 4 cycles, then room 1 is re-served only after the other pending rooms.
REQ-033 Reset asserted in CANCEL -> that cycle cancel_out=0; next cycle all outputs 0 and state IDLE; ack held high through reset release -> no transition.
